cache_evict_fill: RTL

CACHE_EVICT_FILL -- requirements
Module: cache_evict_fill

---
 rtl/cache_evict_fill.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cache_evict_fill.sv
// rtl/cache_evict_fill.sv - victim writeback and line fill sequencer for a set-associative cache
// One miss at a time: optional dirty-victim writeback, then a full line fill, then tag/LRU commit.
module cache_evict_fill #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 9,
  parameter int OFFSETLEN = 5,
  parameter int TAGLEN    = 18,
  parameter int BEATBYTES = 8,
  localparam int BEATS    = (2 ** OFFSETLEN) / BEATBYTES,
  localparam int BEAT_W   = $clog2(BEATS),
  localparam int BB_W     = $clog2(BEATBYTES),
  localparam int ADR_W    = TAGLEN + SETLEN + OFFSETLEN
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_miss_req,
  input  logic [SETLEN-1:0]  i_miss_set,
  input  logic [TAGLEN-1:0]  i_miss_tag,
  input  logic [NUMWAYS-1:0] i_victim_way,
  input  logic [NUMWAYS-1:0] i_dirty_way,
  input  logic [TAGLEN-1:0]  i_victim_tag,
  input  logic               i_bus_ack,
  input  logic               i_bus_err,
  output logic               o_bus_req,
  output logic               o_bus_write,
  output logic [ADR_W-1:0]   o_bus_adr,
  output logic [BEAT_W-1:0]  o_beat_count,
  output logic [NUMWAYS-1:0] o_sel_way,
  output logic               o_line_write_en,
  output logic               o_clear_valid,
  output logic               o_set_valid,
  output logic               o_clear_dirty,
  output logic               o_lru_write_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2,
    S_COMPLETE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SETLEN-1:0]  r_set;
  logic [TAGLEN-1:0]  r_miss_tag;
  logic [TAGLEN-1:0]  r_victim_tag;
  logic [NUMWAYS-1:0] r_sel_way;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_entry;

  logic [NUMWAYS-1:0] w_low_bit;
  logic [NUMWAYS-1:0] w_sel_way;
  logic               w_dirty;
  logic               w_accept;
  logic               w_active;
  logic               w_beat_done;
  logic               w_abort;
  logic               w_last_beat;

  // Isolate the lowest set victim bit; an empty victim vector falls back to way 0.
  assign w_low_bit   = i_victim_way & (~i_victim_way + NUMWAYS'(1));
  assign w_sel_way   = (i_victim_way == '0) ? NUMWAYS'(1) : w_low_bit;
  assign w_dirty     = |(w_sel_way & i_dirty_way);
  assign w_accept    = (r_state == S_IDLE) && i_miss_req;

  assign w_active    = (r_state == S_WRITEBACK) || (r_state == S_FILL);
  assign w_abort     = w_active && i_bus_err;
  assign w_beat_done = w_active && i_bus_ack && !i_bus_err;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_miss_req) begin
          w_next = w_dirty ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_beat_done && w_last_beat) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_beat_done && w_last_beat) begin
          w_next = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Miss context is captured once per request and held until the next accepted miss.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_set        <= '0;
      r_miss_tag   <= '0;
      r_victim_tag <= '0;
      r_sel_way    <= '0;
      r_beat       <= '0;
      r_entry      <= 1'b0;
    end else begin
      r_entry <= w_accept;
      if (w_accept) begin
        r_set        <= i_miss_set;
        r_miss_tag   <= i_miss_tag;
        r_victim_tag <= i_victim_tag;
        r_sel_way    <= w_sel_way;
        r_beat       <= '0;
      end else if (w_abort) begin
        r_beat <= '0;
      end else if (w_beat_done) begin
        r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    o_bus_req       = 1'b0;
    o_bus_write     = 1'b0;
    o_bus_adr       = '0;
    o_line_write_en = 1'b0;
    o_set_valid     = 1'b0;
    o_clear_dirty   = 1'b0;
    o_lru_write_en  = 1'b0;
    o_done          = 1'b0;
    o_error         = 1'b0;
    o_clear_valid   = r_entry;
    o_beat_count    = r_beat;
    o_sel_way       = r_sel_way;
    o_busy          = (r_state != S_IDLE);
    case (r_state)
      S_WRITEBACK: begin
        o_bus_req   = 1'b1;
        o_bus_write = 1'b1;
        o_bus_adr   = {r_victim_tag, r_set, r_beat, {BB_W{1'b0}}};
        o_error     = i_bus_err;
      end
      S_FILL: begin
        o_bus_req       = 1'b1;
        o_bus_adr       = {r_miss_tag, r_set, r_beat, {BB_W{1'b0}}};
        o_line_write_en = i_bus_ack && !i_bus_err;
        o_error         = i_bus_err;
      end
      S_COMPLETE: begin
        o_set_valid    = 1'b1;
        o_clear_dirty  = 1'b1;
        o_lru_write_en = 1'b1;
        o_done         = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
